// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Two-requester round-robin arbiter and sequencer in front of  |
// |               a single-port synchronous memory with registered read data.  |
// |               One transaction is in flight at a time:                      |
// |               IDLE -> ACCESS (-> CAPTURE for reads) -> IDLE.               |
// | Ports       : clk, rst_n (async, active low)                               |
// |               reqN_valid/we/addr/wdata in, reqN_ready out (N = 0,1)        |
// |               rspN_valid/rspN_rdata out (one-cycle response pulse)         |
// |               mem_we/mem_addr/mem_wdata out, mem_rdata in                  |
// | Option      : define MEM_ARB_STATS_EN to add the stats_clr input and the   |
// |               saturating 16-bit grant_cnt0/grant_cnt1 outputs.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic any_valid;
  logic winner;

  // Round-robin only matters on contention: the requester that did not win
  // last time goes first. A lone requester always wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant_q;
    end else begin
      winner = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !winner;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          // The request is latched straight into the memory-facing
          // registers so it is presented during the ACCESS cycle and then
          // simply held afterwards.
          owner_d      = winner;
          last_grant_d = winner;
          we_d         = winner ? req1_we    : req0_we;
          mem_we_d     = winner ? req1_we    : req0_we;
          mem_addr_d   = winner ? req1_addr  : req0_addr;
          mem_wdata_d  = winner ? req1_wdata : req0_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_rdata_d = '0;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_rdata_d = '0;
          end
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // The memory's registered read data for the ACCESS address is
        // valid during this cycle.
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_rdata_d = mem_rdata;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_rdata_d = mem_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;

  // Clear wins over a same-cycle grant; counters stick at all-ones.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (stats_clr) begin
      grant_cnt0_d = '0;
      grant_cnt1_d = '0;
    end else begin
      if (req0_ready && (grant_cnt0_q != 16'hFFFF)) grant_cnt0_d = grant_cnt0_q + 16'd1;
      if (req1_ready && (grant_cnt1_q != 16'hFFFF)) grant_cnt1_d = grant_cnt1_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Self-checking bench for mem_arbiter with a behavioural       |
// |               256x8 synchronous memory and a transaction-level reference   |
// |               model (grant order, response timing, memory contents).       |
// |               Stats counters are checked when MEM_ARB_STATS_EN is defined. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [7:0] req0_addr, req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [7:0] req1_addr, req1_wdata, rsp1_rdata;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_ARB_STATS_EN
    .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .mem_rdata(mem_rdata)
  );

  // Behavioural single-port memory with registered read data.
  logic [7:0] mem_arr [256];
  logic       mem_clear;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 8'h00;
    end else if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_arr[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one transaction at a time, response due at a
  // fixed cycle after acceptance.
  int         cyc;
  int         next_free;
  bit         pend_active;
  int         pend_cyc;
  int         pend_owner;
  logic [7:0] pend_data;
  int         last_grant;
  logic [7:0] last_rd [2];
  logic [7:0] ref_mem [256];
  int         gcnt [2];
  bit         obs_rdy [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    next_free   = cyc;
    pend_active = 1'b0;
    last_grant  = 1;
    last_rd[0]  = 8'h00;
    last_rd[1]  = 8'h00;
    gcnt[0]     = 0;
    gcnt[1]     = 0;
    obs_rdy[0]  = 1'b0;
    obs_rdy[1]  = 1'b0;
  endtask

  task automatic set_req(input int n, input bit v, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // return 1 time unit after the next rising edge for new stimulus.
  task automatic run_cycle();
    bit e0, e1, ev0, ev1, we;
    int o;
    logic [7:0] a, d;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (cyc >= next_free) begin
      if (req0_valid && req1_valid) begin
        if (last_grant == 1) e0 = 1'b1; else e1 = 1'b1;
      end else if (req0_valid) begin
        e0 = 1'b1;
      end else if (req1_valid) begin
        e1 = 1'b1;
      end
    end
    obs_rdy[0] = req0_ready;
    obs_rdy[1] = req1_ready;
    chk("req0_ready", 16'(req0_ready), 16'(e0));
    chk("req1_ready", 16'(req1_ready), 16'(e1));

    ev0 = pend_active && (pend_cyc == cyc) && (pend_owner == 0);
    ev1 = pend_active && (pend_cyc == cyc) && (pend_owner == 1);
    if (ev0) last_rd[0] = pend_data;
    if (ev1) last_rd[1] = pend_data;
    if (pend_active && (pend_cyc == cyc)) pend_active = 1'b0;
    chk("rsp0_valid", 16'(rsp0_valid), 16'(ev0));
    chk("rsp1_valid", 16'(rsp1_valid), 16'(ev1));
    chk("rsp0_rdata", 16'(rsp0_rdata), 16'(last_rd[0]));
    chk("rsp1_rdata", 16'(rsp1_rdata), 16'(last_rd[1]));
`ifdef MEM_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, 16'(gcnt[0]));
    chk("grant_cnt1", grant_cnt1, 16'(gcnt[1]));
`endif

    if (e0 || e1) begin
      o  = e1 ? 1 : 0;
      we = e1 ? req1_we    : req0_we;
      a  = e1 ? req1_addr  : req0_addr;
      d  = e1 ? req1_wdata : req0_wdata;
      if (we) begin
        ref_mem[a] = d;
        pend_data  = 8'h00;
        next_free  = cyc + 2;
      end else begin
        pend_data  = ref_mem[a];
        next_free  = cyc + 3;
      end
      pend_cyc    = next_free;
      pend_active = 1'b1;
      pend_owner  = o;
      last_grant  = o;
    end
`ifdef MEM_ARB_STATS_EN
    if (stats_clr) begin
      gcnt[0] = 0;
      gcnt[1] = 0;
    end else begin
      if (e0 && gcnt[0] < 65535) gcnt[0]++;
      if (e1 && gcnt[1] < 65535) gcnt[1]++;
    end
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  // Hold the presented request until the DUT accepts it (bounded).
  task automatic wait_acc(input int n);
    int k;
    k = 0;
    do begin
      run_cycle();
      k++;
    end while (!obs_rdy[n] && k < 20);
    chk($sformatf("accept_req%0d", n), 16'(obs_rdy[n]), 16'd1);
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`ifdef MEM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_mem_we",     16'(mem_we),     16'd0);
    chk("rst_mem_addr",   16'(mem_addr),   16'd0);
    chk("rst_mem_wdata",  16'(mem_wdata),  16'd0);
    chk("rst_rsp0_valid", 16'(rsp0_valid), 16'd0);
    chk("rst_rsp1_valid", 16'(rsp1_valid), 16'd0);
    chk("rst_rsp0_rdata", 16'(rsp0_rdata), 16'd0);
    chk("rst_rsp1_rdata", 16'(rsp1_rdata), 16'd0);
`ifdef MEM_ARB_STATS_EN
    chk("rst_grant_cnt0", grant_cnt0, 16'd0);
    chk("rst_grant_cnt1", grant_cnt1, 16'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ng;
    bit got0, got1;
    cyc       = 0;
    rst_n     = 1'b1;
    mem_clear = 1'b1;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    #2;
    apply_reset();
    mem_clear = 1'b0;

    // Contention in the first IDLE after reset: req0 wins, then alternation.
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      run_cycle();
      if (obs_rdy[0] || obs_rdy[1]) begin
        chk($sformatf("grant_order%0d", ng), 16'(obs_rdy[1]), 16'(ng % 2));
        ng++;
      end
    end
    chk("contention_grants", 16'(ng), 16'd4);
    drain(4);

    // req0 write 0x10 <- 0xA5: memory strobe during the ACCESS cycle.
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    wait_acc(0);
    chk("wr_mem_we",    16'(mem_we),    16'd1);
    chk("wr_mem_addr",  16'(mem_addr),  16'h10);
    chk("wr_mem_wdata", 16'(mem_wdata), 16'hA5);
    run_cycle();
    chk("wr_mem_we_off", 16'(mem_we), 16'd0);
    drain(3);

    // req0 reads the value back.
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    wait_acc(0);
    drain(4);
    chk("rd_back_rdata", 16'(rsp0_rdata), 16'hA5);

    // req1 writes 0x20 while req0 waits to read it; req1 wins (req0 was last).
    set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
    set_req(1, 1'b1, 1'b1, 8'h20, 8'hFF);
    got0 = 1'b0;
    got1 = 1'b0;
    for (int k = 0; k < 20 && !(got0 && got1); k++) begin
      run_cycle();
      if (obs_rdy[0]) begin got0 = 1'b1; req0_valid = 1'b0; end
      if (obs_rdy[1]) begin got1 = 1'b1; req1_valid = 1'b0; end
    end
    chk("raw_both_accepted", 16'({got0, got1}), 16'b11);
    drain(4);
    chk("raw_rdata0", 16'(rsp0_rdata), 16'hFF);
    chk("raw_rdata1", 16'(rsp1_rdata), 16'h00);

    // Reset while a read is in CAPTURE: no response afterwards.
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    wait_acc(0);
    run_cycle();
    apply_reset();
    drain(5);

`ifdef MEM_ARB_STATS_EN
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, 1'b1, 8'(8'h30 + i), 8'(i));
      wait_acc(0);
      drain(2);
    end
    for (int i = 0; i < 2; i++) begin
      set_req(1, 1'b1, 1'b1, 8'(8'h40 + i), 8'(i));
      wait_acc(1);
      drain(2);
    end
    chk("stats_cnt0", grant_cnt0, 16'd3);
    chk("stats_cnt1", grant_cnt1, 16'd2);
    stats_clr = 1'b1;
    run_cycle();
    stats_clr = 1'b0;
    chk("stats_clr_cnt0", grant_cnt0, 16'd0);
    chk("stats_clr_cnt1", grant_cnt1, 16'd0);
`endif

    // Randomised traffic; a pending request stays stable until accepted.
    for (int k = 0; k < 3000; k++) begin
      for (int n = 0; n < 2; n++) begin
        bit held;
        held = (n == 0) ? (req0_valid && !obs_rdy[0]) : (req1_valid && !obs_rdy[1]);
        if (!held) begin
          set_req(n, ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                  8'($urandom));
        end
      end
`ifdef MEM_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 99) < 3);
`endif
      run_cycle();
    end
`ifdef MEM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    drain(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 8-bit, 256-deep single-port synchronous memory.
- Accepts read/write requests over valid/ready handshakes and grants one transaction at a time, round-robin.
- Drives the memory's write enable, address and write-data inputs, and captures its registered read data.
- Returns a per-requester response pulse: read data, or a write acknowledge.

Parameters:
- ADDR_W, 8, address width; must match the memory address bus.
- DATA_W, 8, data width; must match the memory data buses.

Ports:
- clk  input  1  rising-edge clock, shared with the memory.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a transaction pending.
- req0_we  input  1  1 = write, 0 = read.
- req0_addr  input  ADDR_W  target address.
- req0_wdata  input  DATA_W  write data.
- req0_ready  output  1  request accepted this cycle.
- rsp0_valid  output  1  one-cycle response pulse.
- rsp0_rdata  output  DATA_W  read data; 0 on write acknowledge.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as requester 0.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory registered read data; valid the cycle after a read is presented.

Behaviour:
- Reset values: state=IDLE; mem_we=0; mem_addr=0; mem_wdata=0; rsp*_valid=0; rsp*_rdata=0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE:
  - winner = the only valid requester, or, when both are valid, the requester that is not last_grant.
  - reqN_ready is combinational: (state==IDLE) && valid && winner==N.
  - On acceptance: latch we/addr/wdata/owner, set last_grant=owner, go to ACCESS.
  - No valid requester: stay in IDLE.
- ACCESS, exactly 1 cycle:
  - mem_addr and mem_wdata driven from the latched request; mem_we = latched we.
  - Write: go to IDLE and register rsp<owner>_valid=1 with rdata=0 in the next cycle.
  - Read: go to CAPTURE.
- CAPTURE, 1 cycle: sample mem_rdata into rsp<owner>_rdata, register rsp<owner>_valid=1 for the next cycle, go to IDLE.
- Latency from the accept cycle A: write response at A+2; read response at A+3.
  - Back-to-back writes: 2 cycles each.
  - Back-to-back reads: 3 cycles each.
- Outside ACCESS: mem_we=0, and mem_addr/mem_wdata hold their last values. The memory's idle reads are ignored.
- Response pulses last exactly 1 cycle. rspN_rdata holds its value until the next response for N.
- A response pulse and a new acceptance in the same IDLE cycle are legal.
- Requester rule: fields must be stable while valid && !ready. The arbiter does not check this.
- A single active requester may be granted consecutively; round-robin applies only on contention.
- Read-after-write to the same address, either requester: the read returns the newly written data, because the write completes before the next grant.
- Reset mid-operation: the in-flight transaction is dropped and no response is issued. A write whose ACCESS edge coincides with reset assertion is not guaranteed to land.
- Address wrap: none; ADDR_W covers the full memory.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds output ports grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counter increments on every acceptance for its requester, saturates at 16'hFFFF, and resets to 0.
  - Adds input stats_clr (1 bit): synchronous clear of both counters; clear has priority over increment in the same cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0 writes addr 8'h10 data 8'hA5 -> req0_ready at A; mem_we=1, mem_addr=8'h10 at A+1; rsp0_valid at A+2 with rdata=0.
- req0 reads 8'h10 after that write -> rsp0_valid at A+3 with rsp0_rdata=8'hA5; rsp1_valid stays 0.
- Both valid in the first IDLE after reset (req0 read 8'h01, req1 read 8'h02) -> req0 granted first, req1 granted next; sustained contention alternates 0,1,0,1.
- req1 writes 8'hFF to 8'h20 while req0 is waiting to read 8'h20 -> req0 read returns 8'hFF.
- Assert rst_n=0 during CAPTURE of a read -> no rsp pulse, state IDLE, all outputs at reset values immediately.
- With MEM_ARB_STATS_EN: 3 grants to req0 and 2 to req1 -> grant_cnt0=3, grant_cnt1=2; stats_clr pulse -> both 0 the next cycle.
